mtl_cursor_scheduler: RTL and testbench

Arbitrates and sequences updates to the cursor-square position and visibility consumed by the MTL colour selector. It sits between two requesters (touch controller and host/SPI command path) and the colour selector. It buffers one accepted request and commits it only on the display's end-of-frame pulse, so a frame is never drawn with a half-updated position. It also clamps coordinates to the drawable area and hides the cursor after a configurable number of frames without touch activity.

---
 rtl/mtl_cursor_scheduler.sv | 134 +++++++++++++
 tb/tb_mtl_cursor_scheduler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mtl_cursor_scheduler.sv
// Cursor position/visibility scheduler: arbitrates touch and host requests, buffers one,
// and commits it to the colour-selector outputs only on the end-of-frame pulse.
module mtl_cursor_scheduler #(
  parameter int H_RES       = 800,
  parameter int V_RES       = 480,
  parameter int MARGIN      = 20,
  parameter int IDLE_FRAMES = 60,
  parameter int INIT_X      = 200,
  parameter int INIT_Y      = 200
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iTouchValid,
  output logic       oTouchReady,
  input  logic [9:0] iTouchX,
  input  logic [8:0] iTouchY,
  input  logic       iHostValid,
  output logic       oHostReady,
  input  logic [9:0] iHostX,
  input  logic [8:0] iHostY,
  input  logic       iHostHide,
  input  logic       iEndFrame,
  output logic [9:0] oCurX,
  output logic [8:0] oCurY,
  output logic       oCurVisible,
  output logic       oCommit,
  output logic [2:0] oDbgState
);

  // Handshake: a request transfers on a cycle where valid and ready are both high;
  // the requester holds valid and data stable until then. Readies are combinational.

  typedef enum logic { EMPTY = 1'b0, PENDING = 1'b1 } buf_state_t;
  typedef enum logic { TOUCH = 1'b0, HOST = 1'b1 } src_t;

  localparam int IW = (IDLE_FRAMES > 0) ? $clog2(IDLE_FRAMES + 1) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_FRAMES);
  localparam logic [9:0] X_MIN = 10'(MARGIN);
  localparam logic [9:0] X_MAX = 10'(H_RES - 1 - MARGIN);
  localparam logic [8:0] Y_MIN = 9'(MARGIN);
  localparam logic [8:0] Y_MAX = 9'(V_RES - 1 - MARGIN);

  buf_state_t    state;
  src_t          rr;
  src_t          buf_src;
  logic [9:0]    buf_x;
  logic [8:0]    buf_y;
  logic          buf_hide;
  logic [IW-1:0] idle_cnt;

  logic       touch_fire;
  logic       host_fire;
  logic [9:0] acc_x;
  logic [8:0] acc_y;

  function automatic logic [9:0] clamp_x(input logic [9:0] v);
    if (v < X_MIN)      clamp_x = X_MIN;
    else if (v > X_MAX) clamp_x = X_MAX;
    else                clamp_x = v;
  endfunction

  function automatic logic [8:0] clamp_y(input logic [8:0] v);
    if (v < Y_MIN)      clamp_y = Y_MIN;
    else if (v > Y_MAX) clamp_y = Y_MAX;
    else                clamp_y = v;
  endfunction

  assign oTouchReady = (state == EMPTY) && (!iHostValid  || rr == TOUCH);
  assign oHostReady  = (state == EMPTY) && (!iTouchValid || rr == HOST);
  assign touch_fire  = iTouchValid && oTouchReady;
  assign host_fire   = iHostValid  && oHostReady;

  assign acc_x = clamp_x(touch_fire ? iTouchX : iHostX);
  assign acc_y = clamp_y(touch_fire ? iTouchY : iHostY);

  assign oDbgState = {rr, buf_src, state};

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= EMPTY;
      rr          <= TOUCH;
      buf_src     <= TOUCH;
      buf_x       <= '0;
      buf_y       <= '0;
      buf_hide    <= 1'b0;
      idle_cnt    <= '0;
      oCurX       <= 10'(INIT_X);
      oCurY       <= 9'(INIT_Y);
      oCurVisible <= 1'b1;
      oCommit     <= 1'b0;
    end else begin
      oCommit <= 1'b0;

      case (state)
        EMPTY: begin
          if (touch_fire || host_fire) begin
            state    <= PENDING;
            buf_src  <= touch_fire ? TOUCH : HOST;
            buf_x    <= acc_x;
            buf_y    <= acc_y;
            buf_hide <= host_fire && iHostHide;
            rr       <= touch_fire ? HOST : TOUCH;
          end
        end
        PENDING: begin
          if (iEndFrame) begin
            state   <= EMPTY;
            oCommit <= 1'b1;
            if (buf_hide) begin
              oCurVisible <= 1'b0;
            end else begin
              oCurX       <= buf_x;
              oCurY       <= buf_y;
              oCurVisible <= 1'b1;
            end
          end
        end
        default: state <= EMPTY;
      endcase

      // Idle tracking runs on every frame that does not show a new visible position;
      // a hide commit still counts as an idle frame.
      if (iEndFrame) begin
        if (state == PENDING && !buf_hide) begin
          idle_cnt <= '0;
        end else if (IDLE_FRAMES != 0 && idle_cnt != IDLE_MAX) begin
          idle_cnt <= idle_cnt + 1'b1;
          if (idle_cnt + 1'b1 == IDLE_MAX) oCurVisible <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mtl_cursor_scheduler.sv
// Directed bench for mtl_cursor_scheduler (IDLE_FRAMES=3): handshake, arbitration,
// clamping, commit timing, idle auto-hide, host hide and mid-operation reset.
module tb_mtl_cursor_scheduler;

  logic       clk;
  logic       rst_n;
  logic       touch_valid;
  logic       touch_ready;
  logic [9:0] touch_x;
  logic [8:0] touch_y;
  logic       host_valid;
  logic       host_ready;
  logic [9:0] host_x;
  logic [8:0] host_y;
  logic       host_hide;
  logic       end_frame;
  logic [9:0] cur_x;
  logic [8:0] cur_y;
  logic       cur_visible;
  logic       commit;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mtl_cursor_scheduler #(
    .H_RES(800), .V_RES(480), .MARGIN(20), .IDLE_FRAMES(3), .INIT_X(200), .INIT_Y(200)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n),
    .iTouchValid(touch_valid), .oTouchReady(touch_ready), .iTouchX(touch_x), .iTouchY(touch_y),
    .iHostValid(host_valid), .oHostReady(host_ready), .iHostX(host_x), .iHostY(host_y),
    .iHostHide(host_hide), .iEndFrame(end_frame),
    .oCurX(cur_x), .oCurY(cur_y), .oCurVisible(cur_visible), .oCommit(commit),
    .oDbgState(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on the falling edge, checks happen there too
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    end_frame = 1'b1;
    tick();
    end_frame = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int x, input int y, input int vis, input int cm);
    chk({tag, ".x"},      32'(cur_x),       32'(x));
    chk({tag, ".y"},      32'(cur_y),       32'(y));
    chk({tag, ".vis"},    32'(cur_visible), 32'(vis));
    chk({tag, ".commit"}, 32'(commit),      32'(cm));
  endtask

  initial begin
    rst_n = 1'b0;
    touch_valid = 1'b0; touch_x = '0; touch_y = '0;
    host_valid = 1'b0; host_x = '0; host_y = '0; host_hide = 1'b0;
    end_frame = 1'b0;
    #12;
    chk_out("reset", 200, 200, 1, 0);
    chk("reset.touch_ready", 32'(touch_ready), 1);
    chk("reset.host_ready",  32'(host_ready),  1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single touch, end of frame ten cycles later
    touch_valid = 1'b1; touch_x = 10'd300; touch_y = 9'd150;
    #1;
    chk("t1.touch_ready", 32'(touch_ready), 1);
    tick();
    touch_valid = 1'b0;
    #1;
    chk("t1.pending_ready", 32'(touch_ready), 0);
    chk_out("t1.hold", 200, 200, 1, 0);
    repeat (9) tick();
    frame_pulse();
    chk_out("t1.commit", 300, 150, 1, 1);
    tick();
    chk_out("t1.after", 300, 150, 1, 0);

    // clamping: touch low-x/high-y, then host high-x/low-y
    touch_valid = 1'b1; touch_x = 10'd5; touch_y = 9'd475;
    tick();
    touch_valid = 1'b0;
    frame_pulse();
    chk_out("clamp.touch", 20, 459, 1, 1);
    host_valid = 1'b1; host_x = 10'd799; host_y = 9'd0; host_hide = 1'b0;
    #1;
    chk("clamp.host_ready", 32'(host_ready), 1);
    tick();
    host_valid = 1'b0;
    frame_pulse();
    chk_out("clamp.host", 779, 20, 1, 1);

    // round robin with both requesters valid: touch, host, touch
    touch_valid = 1'b1; touch_x = 10'd100; touch_y = 9'd50;
    host_valid  = 1'b1; host_x  = 10'd600; host_y  = 9'd400;
    #1;
    chk("rr1.touch_ready", 32'(touch_ready), 1);
    chk("rr1.host_ready",  32'(host_ready),  0);
    tick();
    touch_x = 10'd110; touch_y = 9'd60;
    #1;
    chk("rr1.pend_touch_ready", 32'(touch_ready), 0);
    chk("rr1.pend_host_ready",  32'(host_ready),  0);
    frame_pulse();
    chk_out("rr1.commit", 100, 50, 1, 1);
    chk("rr2.touch_ready", 32'(touch_ready), 0);
    chk("rr2.host_ready",  32'(host_ready),  1);
    tick();
    host_valid = 1'b0;
    #1;
    chk("rr2.pend_touch_ready", 32'(touch_ready), 0);
    frame_pulse();
    chk_out("rr2.commit", 600, 400, 1, 1);
    chk("rr3.touch_ready", 32'(touch_ready), 1);
    tick();
    touch_valid = 1'b0;
    frame_pulse();
    chk_out("rr3.commit", 110, 60, 1, 1);

    // accept coincides with end of frame: no commit until the next pulse
    touch_valid = 1'b1; touch_x = 10'd700; touch_y = 9'd100;
    end_frame = 1'b1;
    tick();
    touch_valid = 1'b0; end_frame = 1'b0;
    #1;
    chk_out("same.nocommit", 110, 60, 1, 0);
    tick();
    chk_out("same.wait", 110, 60, 1, 0);
    frame_pulse();
    chk_out("same.commit", 700, 100, 1, 1);

    // idle auto-hide after three frames without activity
    frame_pulse();
    chk_out("idle1", 700, 100, 1, 0);
    frame_pulse();
    chk_out("idle2", 700, 100, 1, 0);
    frame_pulse();
    chk_out("idle3", 700, 100, 0, 0);
    frame_pulse();
    chk_out("idle4", 700, 100, 0, 0);
    touch_valid = 1'b1; touch_x = 10'd50; touch_y = 9'd30;
    tick();
    touch_valid = 1'b0;
    frame_pulse();
    chk_out("idle.restore", 50, 30, 1, 1);

    // host hide commit keeps the position
    host_valid = 1'b1; host_x = 10'd9; host_y = 9'd9; host_hide = 1'b1;
    tick();
    host_valid = 1'b0;
    frame_pulse();
    chk_out("hide.commit", 50, 30, 0, 1);

    // pending hide discarded by reset
    host_valid = 1'b1; host_x = 10'd123; host_y = 9'd45; host_hide = 1'b1;
    tick();
    host_valid = 1'b0; host_hide = 1'b0;
    #1;
    chk("rst.pending_ready", 32'(touch_ready), 0);
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 200, 200, 1, 0);
    chk("rst.touch_ready", 32'(touch_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    frame_pulse();
    chk_out("rst.noframe", 200, 200, 1, 0);
    tick();
    chk_out("rst.after", 200, 200, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
